servo_cmd_arbiter: RTL and testbench
====================================

# servo_cmd_arbiter

Round-robin arbiter and transaction sequencer that shares one `servo_avalon` slave between up to `NUM_REQ` command sources on the forklift controller (steering, lift, sensor sweep, diagnostics). Each granted requester's pulse time is issued as one Avalon write. The arbiter then polls the slave's read port until a nonzero PWM-response measurement returns or a timeout expires. Result, timeout flag and a one-cycle acknowledge go back to the granted requester.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `DATA_W`, 32: pulse-time and readdata width.
- `TIMEOUT_CYC`, 1000: maximum POLL cycles before abort (≥2).
- `MIN_PULSE`, 1: lower clamp bound (clamp build only).
- `MAX_PULSE`, 200000: upper clamp bound (clamp build only).

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  NUM_REQ  request per source; hold until `ack`.
- `req_pulse`  in  NUM_REQ*DATA_W  flat pulse-time vector; slice i at [i*DATA_W +: DATA_W].
- `ack`  out  NUM_REQ  one-cycle completion pulse to granted source.
- `resp_data`  out  DATA_W  last measured response (0 on timeout).
- `resp_timeout`  out  1  last transaction timed out.
- `resp_clamped`  out  1  last pulse was clamped.
- `busy`  out  1  high in every state except IDLE.
- `srv_cs`  out  1  slave chip select.
- `srv_write`  out  1  slave write strobe.
- `srv_read`  out  1  slave read strobe.
- `srv_writedata`  out  DATA_W  pulse time to slave.
- `srv_readdata`  in  DATA_W  slave measurement.

## Operation
- FSM states: IDLE, WRITE, POLL, DONE.
- IDLE:
  - If any `req` bit is high, search from `last_grant+1` modulo NUM_REQ.
  - Latch the first set index into `grant_idx`, latch its `req_pulse` slice into `pulse_q`, go to WRITE.
  - Otherwise stay in IDLE.
- WRITE, exactly one cycle:
  - `srv_cs=1`, `srv_write=1`, `srv_writedata=pulse_q`.
  - Clear `poll_cnt`, go to POLL.
- POLL:
  - `srv_cs=1`, `srv_read=1`.
  - `srv_readdata` is sampled every cycle.
  - Nonzero: latch it to `resp_data`, `resp_timeout=0`, go to DONE.
  - Zero with `poll_cnt==TIMEOUT_CYC-1`: `resp_data=0`, `resp_timeout=1`, go to DONE.
  - Zero otherwise: increment `poll_cnt`.
- DONE, one cycle:
  - `ack[grant_idx]=1`, `last_grant=grant_idx`, go to IDLE.
- `resp_*` registers hold their value until the next DONE.
- `req` is sampled only in IDLE. Dropping `req` mid-transaction does not abort it; the transaction completes and `ack` still pulses.
- `srv_writedata` holds `pulse_q` outside WRITE. The strobes are 0 outside their states.
- `poll_cnt` width is clog2(TIMEOUT_CYC); it never wraps.

## Timing
- Reset values:
  - All outputs 0; FSM in IDLE.
  - `last_grant=NUM_REQ-1`, so requester 0 has first priority.
  - `pulse_q=0`, `poll_cnt=0`.
- Reset asserted in any state returns to IDLE on the next edge. No `ack` is issued and strobes drop the same cycle reset is sampled.
- Latency, req high in cycle 0 (IDLE):
  - WRITE in cycle 1.
  - First POLL in cycle 2.
  - If readdata is nonzero in cycle 2, DONE/`ack` in cycle 3.
  - Minimum req-to-ack is 3 cycles.
- Timeout path: POLL lasts exactly TIMEOUT_CYC cycles, so `ack` arrives at cycle 2+TIMEOUT_CYC.
- Back-to-back: after DONE there is one IDLE cycle before the next WRITE. A continuously-requesting source waits for all other active sources (fairness).
- Simultaneous requests in IDLE: the round-robin pointer alone decides; there is no fixed priority after reset.

## Configuration
- Macro `SERVO_ARB_CLAMP_EN` defined:
  - The IDLE latch stores `pulse_q = max(MIN_PULSE, min(MAX_PULSE, req_pulse slice))`, compared unsigned.
  - `resp_clamped` is set at DONE if the latched value differed from the request.
- Macro undefined:
  - The slice is latched unchanged.
  - `resp_clamped` is constant 0; MIN_PULSE and MAX_PULSE are unused.

## Test plan
- Single request:
  - Stimulus: `req=0001`, pulse 3; slave readdata goes to 7 on the first POLL cycle.
  - Response: `srv_write` high one cycle with writedata 3; `ack=0001` 3 cycles after req; `resp_data=7`; `resp_timeout=0`.
- Round robin:
  - Stimulus: `req=1011` held continuously, slave answers immediately.
  - Response: grants in order 0,1,3,0,1,3; each `ack` one cycle wide; `busy` low exactly one cycle between transactions.
- Timeout:
  - Stimulus: TIMEOUT_CYC=10, readdata held 0.
  - Response: exactly 10 POLL cycles; `ack` at cycle 12; `resp_data=0`; `resp_timeout=1`.
- Reset mid-poll:
  - Stimulus: assert `reset` during POLL cycle 4.
  - Response: next edge is IDLE; no `ack`; all strobes 0; the next grant goes to requester 0.
- Request drop:
  - Stimulus: source 2 deasserts `req` during POLL.
  - Response: the transaction finishes and `ack[2]` pulses.
- Clamp (macro defined):
  - Stimulus: pulse 300000 with MAX_PULSE=200000.
  - Response: writedata 200000, `resp_clamped=1`.
  - Without the macro: writedata 300000, `resp_clamped=0`.

Source files
------------

// File: rtl/servo_cmd_arbiter.sv
// Round-robin arbiter that shares one servo_avalon slave: one write of the granted pulse, then read polling until a nonzero response or timeout.
// Optional build macro: SERVO_ARB_CLAMP_EN clamps latched pulse times to [MIN_PULSE, MAX_PULSE].
module servo_cmd_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 1000,
    parameter int MIN_PULSE   = 1,
    parameter int MAX_PULSE   = 200000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_pulse,
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_W-1:0]         resp_data,
    output logic                      resp_timeout,
    output logic                      resp_clamped,
    output logic                      busy,
    output logic                      srv_cs,
    output logic                      srv_write,
    output logic                      srv_read,
    output logic [DATA_W-1:0]         srv_writedata,
    input  logic [DATA_W-1:0]         srv_readdata
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_POLL, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [DATA_W-1:0]   pulse_q, pulse_d;
    logic [CNT_W-1:0]    poll_cnt_q, poll_cnt_d;
    logic [DATA_W-1:0]   resp_data_q, resp_data_d;
    logic                resp_timeout_q, resp_timeout_d;
    logic                resp_clamped_q, resp_clamped_d;
    logic                hit_q, hit_d;

    logic                found;
    logic [IDX_W-1:0]    pick;
    logic [DATA_W-1:0]   pulse_raw;
    logic [DATA_W-1:0]   pulse_in;
    logic                hit_in;

    // Search starts one past the last grant so every active source is served in turn.
    always_comb begin
        int idx;
        found = 1'b0;
        pick  = last_q;
        idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_q) + k) % NUM_REQ;
            if (!found && req[idx[IDX_W-1:0]]) begin
                found = 1'b1;
                pick  = idx[IDX_W-1:0];
            end
        end
    end

    assign pulse_raw = req_pulse[pick*DATA_W +: DATA_W];

`ifdef SERVO_ARB_CLAMP_EN
    localparam logic [DATA_W-1:0] MIN_V = DATA_W'(MIN_PULSE);
    localparam logic [DATA_W-1:0] MAX_V = DATA_W'(MAX_PULSE);
    logic [DATA_W-1:0] pulse_hi_lim;

    always_comb begin
        pulse_hi_lim = (pulse_raw > MAX_V) ? MAX_V : pulse_raw;
        pulse_in     = (pulse_hi_lim < MIN_V) ? MIN_V : pulse_hi_lim;
    end
    assign hit_in = (pulse_in != pulse_raw);
`else
    assign pulse_in = pulse_raw;
    assign hit_in   = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        last_d         = last_q;
        pulse_d        = pulse_q;
        poll_cnt_d     = poll_cnt_q;
        resp_data_d    = resp_data_q;
        resp_timeout_d = resp_timeout_q;
        resp_clamped_d = resp_clamped_q;
        hit_d          = hit_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d = pick;
                    pulse_d = pulse_in;
                    hit_d   = hit_in;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                poll_cnt_d = '0;
                state_d    = S_POLL;
            end
            S_POLL: begin
                if (srv_readdata != '0) begin
                    resp_data_d    = srv_readdata;
                    resp_timeout_d = 1'b0;
                    resp_clamped_d = hit_q;
                    state_d        = S_DONE;
                end else if (poll_cnt_q == CNT_LAST) begin
                    resp_data_d    = '0;
                    resp_timeout_d = 1'b1;
                    resp_clamped_d = hit_q;
                    state_d        = S_DONE;
                end else begin
                    poll_cnt_d = poll_cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                last_d  = grant_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            grant_q        <= '0;
            last_q         <= IDX_W'(NUM_REQ - 1);
            pulse_q        <= '0;
            poll_cnt_q     <= '0;
            resp_data_q    <= '0;
            resp_timeout_q <= 1'b0;
            resp_clamped_q <= 1'b0;
            hit_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            last_q         <= last_d;
            pulse_q        <= pulse_d;
            poll_cnt_q     <= poll_cnt_d;
            resp_data_q    <= resp_data_d;
            resp_timeout_q <= resp_timeout_d;
            resp_clamped_q <= resp_clamped_d;
            hit_q          <= hit_d;
        end
    end

    // Strobes and ack are gated by reset so they drop in the very cycle reset is seen.
    assign busy          = (state_q != S_IDLE) && !reset;
    assign srv_write     = (state_q == S_WRITE) && !reset;
    assign srv_read      = (state_q == S_POLL) && !reset;
    assign srv_cs        = srv_write || srv_read;
    assign srv_writedata = pulse_q;
    assign resp_data     = resp_data_q;
    assign resp_timeout  = resp_timeout_q;
    assign resp_clamped  = resp_clamped_q;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ack
            assign ack[gi] = (state_q == S_DONE) && (grant_q == IDX_W'(gi)) && !reset;
        end
    endgenerate
endmodule

// File: tb/tb_servo_cmd_arbiter.sv
// Directed bench for servo_cmd_arbiter: single request, round robin, timeout, reset mid-poll, request drop, clamp.
module tb_servo_cmd_arbiter;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 32;
    localparam int TO_CYC  = 10;

    logic                      clk;
    logic                      reset;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_pulse;
    logic [NUM_REQ-1:0]        ack;
    logic [DATA_W-1:0]         resp_data;
    logic                      resp_timeout;
    logic                      resp_clamped;
    logic                      busy;
    logic                      srv_cs;
    logic                      srv_write;
    logic                      srv_read;
    logic [DATA_W-1:0]         srv_writedata;
    logic [DATA_W-1:0]         srv_readdata;

    int n_cmp = 0;
    int n_bad = 0;

    servo_cmd_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TIMEOUT_CYC(TO_CYC),
        .MIN_PULSE(1), .MAX_PULSE(200000)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_pulse(req_pulse), .ack(ack),
        .resp_data(resp_data), .resp_timeout(resp_timeout), .resp_clamped(resp_clamped),
        .busy(busy), .srv_cs(srv_cs), .srv_write(srv_write), .srv_read(srv_read),
        .srv_writedata(srv_writedata), .srv_readdata(srv_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rr_exp [6] = '{0, 1, 3, 0, 1, 3};
        int cyc;
        int polls;
        logic [NUM_REQ-1:0] ack_seen;
        logic [31:0] clamp_wd;
        logic        clamp_flag;

        reset        = 1'b1;
        req          = '0;
        srv_readdata = '0;
        req_pulse    = {32'd66, 32'd44, 32'd300000, 32'd3};
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_ack", ack, 0);
        chk("rst_cs", srv_cs, 0);
        chk("rst_write", srv_write, 0);
        chk("rst_read", srv_read, 0);
        chk("rst_wdata", srv_writedata, 0);
        chk("rst_rdata", resp_data, 0);
        chk("rst_tmo", resp_timeout, 0);
        chk("rst_clamp", resp_clamped, 0);
        reset = 1'b0;

        // Single request: ack three cycles after req.
        req = 4'b0001;
        tick();
        chk("single_write", srv_write, 1);
        chk("single_cs", srv_cs, 1);
        chk("single_wdata", srv_writedata, 3);
        chk("single_ack_early", ack, 0);
        srv_readdata = 32'd7;
        tick();
        chk("single_read", srv_read, 1);
        chk("single_write_off", srv_write, 0);
        chk("single_ack_poll", ack, 0);
        tick();
        chk("single_ack", ack, 4'b0001);
        chk("single_rdata", resp_data, 7);
        chk("single_tmo", resp_timeout, 0);
        chk("single_clamp", resp_clamped, 0);
        req = '0;
        tick();
        chk("single_ack_width", ack, 0);
        chk("single_idle", busy, 0);
        $display("txn single: ack=%b resp=%0d", 4'b0001, resp_data);
        srv_readdata = '0;

        // Round robin from a fresh reset so requester 0 goes first.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req          = 4'b1011;
        srv_readdata = 32'd5;
        for (int i = 0; i < 6; i++) begin
            chk("rr_gap", busy, 0);
            tick();
            chk("rr_busy", busy, 1);
            tick();
            tick();
            chk("rr_ack", ack, 32'd1 << rr_exp[i]);
            if (i == 5) req = '0;
            tick();
            chk("rr_ack_width", ack, 0);
            $display("txn rr %0d: expected grant %0d", i, rr_exp[i]);
        end
        tick();
        chk("rr_stop", busy, 0);

        // Timeout: readdata held at zero.
        srv_readdata = '0;
        req = 4'b0001;
        tick();
        cyc      = 1;
        polls    = 0;
        ack_seen = '0;
        for (int k = 0; k < 40; k++) begin
            tick();
            cyc++;
            if (srv_read) polls++;
            if (ack != 0) begin
                ack_seen = ack;
                break;
            end
        end
        chk("tmo_polls", polls, TO_CYC);
        chk("tmo_ack_cycle", cyc, 2 + TO_CYC);
        chk("tmo_ack", ack_seen, 4'b0001);
        chk("tmo_rdata", resp_data, 0);
        chk("tmo_flag", resp_timeout, 1);
        req = '0;
        tick();
        $display("txn timeout: polls=%0d ack_cycle=%0d", polls, cyc);

        // Reset during the fourth POLL cycle of a grant to requester 2.
        req = 4'b0100;
        tick();
        chk("rstp_wdata", srv_writedata, 44);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rstp_polling", srv_read, 1);
        end
        reset = 1'b1;
        req   = 4'b0101;
        #1;
        chk("rstp_read_drop", srv_read, 0);
        chk("rstp_cs_drop", srv_cs, 0);
        chk("rstp_no_ack", ack, 0);
        tick();
        reset = 1'b0;
        chk("rstp_idle", busy, 0);
        chk("rstp_no_ack2", ack, 0);
        chk("rstp_wdata_clr", srv_writedata, 0);
        tick();
        chk("rstp_write", srv_write, 1);
        srv_readdata = 32'd9;
        tick();
        tick();
        chk("rstp_grant0", ack, 4'b0001);
        chk("rstp_rdata", resp_data, 9);
        chk("rstp_tmo", resp_timeout, 0);
        req          = 4'b0100;
        srv_readdata = '0;
        tick();
        $display("txn reset-mid-poll: next grant ack=%b", 4'b0001);

        // Requester 2 drops req during POLL; the transaction still completes.
        tick();
        chk("drop_write", srv_write, 1);
        chk("drop_wdata", srv_writedata, 44);
        tick();
        req = '0;
        tick();
        srv_readdata = 32'd11;
        tick();
        chk("drop_ack", ack, 4'b0100);
        chk("drop_rdata", resp_data, 11);
        chk("drop_clamp", resp_clamped, 0);
        srv_readdata = '0;
        tick();
        $display("txn request-drop: ack=%b resp=%0d", 4'b0100, 11);

        // Out-of-range pulse on requester 1.
`ifdef SERVO_ARB_CLAMP_EN
        clamp_wd   = 32'd200000;
        clamp_flag = 1'b1;
`else
        clamp_wd   = 32'd300000;
        clamp_flag = 1'b0;
`endif
        req = 4'b0010;
        tick();
        chk("clamp_write", srv_write, 1);
        chk("clamp_wdata", srv_writedata, clamp_wd);
        srv_readdata = 32'd4;
        tick();
        tick();
        chk("clamp_ack", ack, 4'b0010);
        chk("clamp_flag", resp_clamped, {31'd0, clamp_flag});
        chk("clamp_rdata", resp_data, 4);
        req          = '0;
        srv_readdata = '0;
        tick();
        tick();
        chk("clamp_idle", busy, 0);
        $display("txn clamp: writedata=%0d clamped=%0d", clamp_wd, clamp_flag);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
